// File: rtl/ariane_pkg.sv
// Shared CSR definitions: the commit op encoding and the address fields that
// carry the minimum privilege level and the read-only marker.
package ariane_pkg;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_t;

  // addr[9:8] is the lowest privilege allowed to touch the CSR
  localparam int unsigned CSR_PRIV_MSB = 9;
  localparam int unsigned CSR_PRIV_LSB = 8;
  // addr[11:10] == 2'b11 marks a read-only CSR
  localparam int unsigned CSR_RO_MSB   = 11;
  localparam int unsigned CSR_RO_LSB   = 10;

  function automatic logic [1:0] csr_min_priv(input logic [11:0] addr);
    return addr[CSR_PRIV_MSB:CSR_PRIV_LSB];
  endfunction

  function automatic logic csr_is_ro(input logic [11:0] addr);
    return addr[CSR_RO_MSB:CSR_RO_LSB] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_commit_unit.sv
// CSR commit unit: takes one CSR op from the commit stage, checks access
// rights, reads the CSR file, optionally writes back the read-modify-write
// result and reports the old value with a one-cycle done pulse.
module csr_commit_unit
  import ariane_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          commit_valid_i,
  output logic          commit_ready_o,
  input  csr_op_t       commit_op_i,
  input  logic [63:0]   commit_wdata_i,
  input  logic [11:0]   csr_addr_i,
  input  logic [1:0]    priv_lvl_i,
  output logic          done_o,
  output logic [63:0]   rdata_o,
  output logic          ex_o,
  output logic          csr_commit_o,
  output logic          csrf_req_o,
  output logic          csrf_we_o,
  output logic [11:0]   csrf_addr_o,
  output logic [63:0]   csrf_wdata_o,
  input  logic          csrf_gnt_i,
  input  logic          csrf_rvalid_i,
  input  logic [63:0]   csrf_rdata_i,
  input  logic          csrf_err_i
);

  typedef enum logic [2:0] {
    IDLE, READ_REQ, READ_WAIT, WRITE_REQ, DONE
  } state_t;

  state_t      state_q, state_d;
  csr_op_t     op_q, op_d;
  logic [63:0] wdata_q, wdata_d;
  logic [11:0] addr_q, addr_d;
  logic [63:0] old_q, old_d;
  logic        ex_q, ex_d;

  logic        acc_fault;
  logic        write_needed;
  logic [63:0] new_val;

  // Access check on the incoming op (privilege too low, or write to RO CSR)
  always_comb begin
    acc_fault = (csr_min_priv(csr_addr_i) > priv_lvl_i) ||
                (csr_is_ro(csr_addr_i) && commit_op_i != CSR_READ);
  end

  // Inline RMW ALU; SET/CLEAR with a zero mask leave the CSR untouched
  always_comb begin
    unique case (op_q)
      CSR_WRITE: new_val = wdata_q;
      CSR_SET:   new_val = old_q | wdata_q;
      CSR_CLEAR: new_val = old_q & ~wdata_q;
      default:   new_val = old_q;
    endcase
    write_needed = (op_q == CSR_WRITE) ||
                   ((op_q == CSR_SET || op_q == CSR_CLEAR) && (wdata_q != '0));
  end

  // Next-state logic; flush only aborts before the read has been granted
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    old_d   = old_q;
    ex_d    = ex_q;
    unique case (state_q)
      IDLE: begin
        if (commit_valid_i && !flush_i) begin
          op_d    = commit_op_i;
          wdata_d = commit_wdata_i;
          addr_d  = csr_addr_i;
          old_d   = '0;
          ex_d    = acc_fault;
          state_d = acc_fault ? DONE : READ_REQ;
        end
      end
      READ_REQ: begin
        if (csrf_gnt_i)   state_d = READ_WAIT;
        else if (flush_i) state_d = IDLE;
      end
      READ_WAIT: begin
        if (csrf_rvalid_i) begin
          if (csrf_err_i) begin
            ex_d    = 1'b1;
            state_d = DONE;
          end else begin
            old_d   = csrf_rdata_i;
            state_d = write_needed ? WRITE_REQ : DONE;
          end
        end
      end
      WRITE_REQ: begin
        if (csrf_gnt_i) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched-operand registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= CSR_READ;
      wdata_q <= '0;
      addr_q  <= '0;
      old_q   <= '0;
      ex_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      old_q   <= old_d;
      ex_q    <= ex_d;
    end
  end

  // Outputs decode only registered state, so they hold steady while a
  // request waits for grant and drop at once on reset
  always_comb begin
    commit_ready_o = (state_q == IDLE);
    done_o         = (state_q == DONE);
    ex_o           = done_o & ex_q;
    rdata_o        = (done_o && !ex_q) ? old_q : '0;
    csr_commit_o   = done_o & ~ex_q;
    csrf_req_o     = (state_q == READ_REQ) || (state_q == WRITE_REQ);
    csrf_we_o      = (state_q == WRITE_REQ);
    csrf_addr_o    = csrf_req_o ? addr_q : '0;
    csrf_wdata_o   = csrf_we_o ? new_val : '0;
  end

endmodule

// File: tb/tb_csr_commit_unit.sv
// Directed bench for csr_commit_unit: inputs change #1 after the rising
// edge, outputs are checked in that same window.
module tb_csr_commit_unit;
  import ariane_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        commit_valid_i;
  logic        commit_ready_o;
  csr_op_t     commit_op_i;
  logic [63:0] commit_wdata_i;
  logic [11:0] csr_addr_i;
  logic [1:0]  priv_lvl_i;
  logic        done_o;
  logic [63:0] rdata_o;
  logic        ex_o;
  logic        csr_commit_o;
  logic        csrf_req_o;
  logic        csrf_we_o;
  logic [11:0] csrf_addr_o;
  logic [63:0] csrf_wdata_o;
  logic        csrf_gnt_i;
  logic        csrf_rvalid_i;
  logic [63:0] csrf_rdata_i;
  logic        csrf_err_i;

  int n_chk  = 0;
  int n_fail = 0;
  int we_seen   = 0;
  int done_seen = 0;

  always #5 clk_i = ~clk_i;

  csr_commit_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .commit_valid_i(commit_valid_i), .commit_ready_o(commit_ready_o),
    .commit_op_i(commit_op_i), .commit_wdata_i(commit_wdata_i),
    .csr_addr_i(csr_addr_i), .priv_lvl_i(priv_lvl_i),
    .done_o(done_o), .rdata_o(rdata_o), .ex_o(ex_o), .csr_commit_o(csr_commit_o),
    .csrf_req_o(csrf_req_o), .csrf_we_o(csrf_we_o), .csrf_addr_o(csrf_addr_o),
    .csrf_wdata_o(csrf_wdata_o), .csrf_gnt_i(csrf_gnt_i),
    .csrf_rvalid_i(csrf_rvalid_i), .csrf_rdata_i(csrf_rdata_i),
    .csrf_err_i(csrf_err_i)
  );

  // write requests and completions seen at each edge
  always @(posedge clk_i) begin
    if (csrf_req_o && csrf_we_o) we_seen++;
    if (done_o) done_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_op(input csr_op_t op, input logic [11:0] addr,
                          input logic [1:0] priv, input logic [63:0] wd);
    commit_valid_i = 1'b1;
    commit_op_i    = op;
    csr_addr_i     = addr;
    priv_lvl_i     = priv;
    commit_wdata_i = wd;
    tick();
    commit_valid_i = 1'b0;
  endtask

  task automatic clear_mon();
    we_seen   = 0;
    done_seen = 0;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; commit_valid_i = 1'b0; commit_op_i = CSR_READ;
    commit_wdata_i = '0; csr_addr_i = '0; priv_lvl_i = 2'b11;
    csrf_gnt_i = 1'b0; csrf_rvalid_i = 1'b0; csrf_rdata_i = '0; csrf_err_i = 1'b0;
    tick(); tick();
    chk("rst_ready", commit_ready_o, 1);
    chk("rst_req",   csrf_req_o, 0);
    chk("rst_done",  done_o, 0);
    chk("rst_ex",    ex_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_commit", csr_commit_o, 0);
    rst_ni = 1'b1;
    tick();

    // CSR_SET 0x300: old 0x1800 | 0x8 -> 0x1808, done 4 cycles after accept
    clear_mon();
    csrf_gnt_i = 1'b1;
    start_op(CSR_SET, 12'h300, 2'b11, 64'h8);          // accept edge
    chk("set_rreq",  csrf_req_o, 1);
    chk("set_rwe",   csrf_we_o, 0);
    chk("set_raddr", csrf_addr_o, 12'h300);
    chk("set_busy",  commit_ready_o, 0);
    tick();                                             // -> READ_WAIT
    csrf_rvalid_i = 1'b1; csrf_rdata_i = 64'h1800;
    chk("set_wait_noreq", csrf_req_o, 0);
    tick();                                             // -> WRITE_REQ
    csrf_rvalid_i = 1'b0;
    chk("set_wreq",   csrf_req_o, 1);
    chk("set_wwe",    csrf_we_o, 1);
    chk("set_wdata",  csrf_wdata_o, 64'h1808);
    chk("set_nodone3", done_o, 0);
    tick();                                             // -> DONE (cycle 4)
    chk("set_done",   done_o, 1);
    chk("set_rdata",  rdata_o, 64'h1800);
    chk("set_commit", csr_commit_o, 1);
    chk("set_ex",     ex_o, 0);
    tick();
    chk("set_done_1cyc", done_o, 0);
    chk("set_ready",  commit_ready_o, 1);

    // CSR_CLEAR with zero mask: read only
    clear_mon();
    start_op(CSR_CLEAR, 12'h300, 2'b11, 64'h0);
    tick();
    csrf_rvalid_i = 1'b1; csrf_rdata_i = 64'h55;
    tick();
    csrf_rvalid_i = 1'b0;
    chk("clr_done",  done_o, 1);
    chk("clr_rdata", rdata_o, 64'h55);
    chk("clr_nowrite", we_seen, 0);
    tick();

    // privilege violation: machine CSR from user mode
    clear_mon();
    start_op(CSR_READ, 12'h300, 2'b00, 64'h0);
    chk("priv_noreq",  csrf_req_o, 0);
    chk("priv_done",   done_o, 1);
    chk("priv_ex",     ex_o, 1);
    chk("priv_commit", csr_commit_o, 0);
    chk("priv_rdata",  rdata_o, 0);
    tick();

    // write to read-only CSR
    start_op(CSR_WRITE, 12'hC00, 2'b11, 64'h1);
    chk("ro_noreq", csrf_req_o, 0);
    chk("ro_ex",    ex_o, 1);
    tick();

    // read error from CSR file aborts the write
    clear_mon();
    start_op(CSR_WRITE, 12'h300, 2'b11, 64'hFF);
    tick();
    csrf_rvalid_i = 1'b1; csrf_err_i = 1'b1; csrf_rdata_i = 64'h1234;
    tick();
    csrf_rvalid_i = 1'b0; csrf_err_i = 1'b0;
    chk("err_done",   done_o, 1);
    chk("err_ex",     ex_o, 1);
    chk("err_rdata",  rdata_o, 0);
    chk("err_nowrite", we_seen, 0);
    tick();

    // grant withheld 5 cycles in WRITE_REQ: request held stable
    start_op(CSR_WRITE, 12'h341, 2'b11, 64'hDEADBEEF00001234);
    tick();
    csrf_rvalid_i = 1'b1; csrf_rdata_i = 64'h77;
    csrf_gnt_i = 1'b0;
    tick();
    csrf_rvalid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req",   csrf_req_o, 1);
      chk("stall_we",    csrf_we_o, 1);
      chk("stall_addr",  csrf_addr_o, 12'h341);
      chk("stall_wdata", csrf_wdata_o, 64'hDEADBEEF00001234);
      chk("stall_nodone", done_o, 0);
      tick();
    end
    csrf_gnt_i = 1'b1;
    tick();
    chk("stall_done",  done_o, 1);
    chk("stall_rdata", rdata_o, 64'h77);
    tick();

    // flush while read request is waiting for grant
    clear_mon();
    csrf_gnt_i = 1'b0;
    start_op(CSR_SET, 12'h300, 2'b11, 64'h4);
    chk("fl_req", csrf_req_o, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_ready", commit_ready_o, 1);
    chk("fl_noreq", csrf_req_o, 0);
    tick(); tick();
    chk("fl_nodone", done_seen, 0);

    // stray rvalid in IDLE must not start anything
    csrf_rvalid_i = 1'b1; csrf_rdata_i = 64'h99;
    tick();
    csrf_rvalid_i = 1'b0;
    chk("stray_ready", commit_ready_o, 1);
    chk("stray_nodone", done_seen, 0);

    // reset in READ_WAIT
    csrf_gnt_i = 1'b1;
    start_op(CSR_WRITE, 12'h300, 2'b11, 64'h5);
    tick();                                             // in READ_WAIT
    #2 rst_ni = 1'b0;
    #1;
    chk("rstmid_req",   csrf_req_o, 0);
    chk("rstmid_ready", commit_ready_o, 1);
    tick();
    chk("rstmid_req_edge",   csrf_req_o, 0);
    chk("rstmid_ready_edge", commit_ready_o, 1);
    chk("rstmid_nodone",     done_seen, 0);
    rst_ni = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/csr_commit_unit.md
CSR_COMMIT_UNIT -- requirements
Module: csr_commit_unit

Interface
REQ-001 SHALL have port clk_i, input, 1, the only clock.
REQ-002 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port flush_i, input, 1, pipeline flush.
REQ-004 SHALL have port commit_valid_i, input, 1, commit stage presents a CSR op.
REQ-005 SHALL have port commit_ready_o, output, 1, unit can accept an op.
REQ-006 SHALL have port commit_op_i, input, csr_op_t, one of CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR.
REQ-007 SHALL have port commit_wdata_i, input, 64, operand from the scoreboard result.
REQ-008 SHALL have port csr_addr_i, input, 12, buffered CSR address.
REQ-009 SHALL have port priv_lvl_i, input, 2, current privilege level.
REQ-010 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rdata_o, output, 64, old CSR value; valid with done_o.
REQ-012 SHALL have port ex_o, output, 1, illegal access; valid with done_o.
REQ-013 SHALL have port csr_commit_o, output, 1, release pulse to the CSR buffer; equals done_o & ~ex_o.
REQ-014 SHALL have the following CSR-file ports:
- csrf_req_o, output, 1.
- csrf_we_o, output, 1.
- csrf_addr_o, output, 12.
- csrf_wdata_o, output, 64.
- csrf_gnt_i, input, 1.
- csrf_rvalid_i, input, 1.
- csrf_rdata_i, input, 64.
- csrf_err_i, input, 1, qualified by csrf_rvalid_i.

Function
REQ-015 SHALL implement FSM states IDLE, READ_REQ, READ_WAIT, WRITE_REQ, DONE.
REQ-016 commit_ready_o SHALL be 1 only in IDLE; in IDLE, commit_valid_i SHALL latch op, wdata and addr, and SHALL transition as follows:
- Privilege violation (csr_addr_i[9:8] > priv_lvl_i): go to DONE with ex_o=1.
- Write to a read-only CSR (csr_addr_i[11:10]==2'b11 with op other than CSR_READ): go to DONE with ex_o=1.
- Otherwise: go to READ_REQ.
REQ-017 READ_REQ SHALL drive csrf_req_o=1, csrf_we_o=0, csrf_addr_o=latched addr, holding until csrf_gnt_i, then go to READ_WAIT.
REQ-018 READ_WAIT SHALL wait for csrf_rvalid_i, capture csrf_rdata_i as old value, and transition as follows:
- csrf_err_i=1: go to DONE with ex_o=1.
- Write needed: go to WRITE_REQ.
- Otherwise: go to DONE.
REQ-019 A write SHALL be needed for CSR_WRITE always, and for CSR_SET/CSR_CLEAR only when wdata is non-zero.
REQ-020 New value SHALL be computed as follows:
- CSR_WRITE: wdata.
- CSR_SET: old | wdata.
- CSR_CLEAR: old & ~wdata.
REQ-021 WRITE_REQ SHALL drive csrf_req_o=1, csrf_we_o=1, csrf_wdata_o=new value, holding until csrf_gnt_i, then go to DONE.
REQ-022 DONE SHALL last exactly one cycle, assert done_o, present rdata_o=old value (0 on exception), then go to IDLE.
REQ-023 Request outputs SHALL be stable while csrf_req_o=1 and csrf_gnt_i=0.
REQ-024 Minimum latency SHALL be 4 cycles from accept to done_o, given immediate gnt and rvalid one cycle after read gnt, with a write.
REQ-025 flush_i SHALL abort to IDLE without done_o in IDLE or READ_REQ before gnt.
REQ-026 flush_i SHALL be ignored once a read is granted, so the op completes.
REQ-027 csrf_rvalid_i outside READ_WAIT SHALL be ignored.

Reset
REQ-028 Reset SHALL force IDLE and clear all latched state; outputs SHALL be commit_ready_o=1 and all others 0.
REQ-029 Reset asserted mid-operation SHALL immediately drop csrf_req_o and complete nothing.

Structure
REQ-030 csr_op_t and the CSR address privilege/read-only field positions SHALL live in ariane_pkg.
REQ-031 The FSM state enum SHALL be local.
REQ-032 The unit SHALL be a single module without sub-modules; the RMW ALU SHALL be inline combinational logic.

Verification
REQ-033 The bench SHALL cover:
- CSR_SET, addr 0x300, priv 2'b11, wdata 0x8, old 0x1800, immediate gnt -> write 0x1808, rdata_o=0x1800, done_o at cycle 4, csr_commit_o=1.
- CSR_CLEAR, wdata 0 -> no write request, done_o, rdata_o=old.
- Addr 0x300 at priv 2'b00 -> no csrf_req_o, done_o with ex_o=1, csr_commit_o=0.
- CSR_WRITE to 0xC00 -> ex_o=1; csrf_err_i on read -> ex_o=1, no write.
- gnt withheld 5 cycles in WRITE_REQ -> request stable throughout; flush_i in READ_REQ -> IDLE, no done_o.
- Reset asserted in READ_WAIT -> csrf_req_o=0, commit_ready_o=1 next edge.
